// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side stream adapter.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned BUF_DEPTH      = 3;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Three-entry circular buffer that absorbs FIFO read data ahead of the stream sink.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [1:0]            rd_idx;
    logic [1:0]            wr_idx;

    // Index advance with wrap at the buffer depth (depth is not a power of two).
    function automatic logic [1:0] idx_inc(input logic [1:0] idx);
        return (idx == 2'(BUF_DEPTH - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

    // Entry writes, index advance and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_idx <= '0;
            wr_idx <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= idx_inc(wr_idx);
            end
            if (pop) begin
                rd_idx <= idx_inc(rd_idx);
            end
            if (push && !pop) begin
                occ <= occ + 2'd1;
            end else if (!push && pop) begin
                occ <= occ - 2'd1;
            end
        end
    end

    assign head = mem[rd_idx];

    // The parent's read credit must keep pushes within capacity.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (occ == 2'(BUF_DEPTH))));

    // Pops are only legal while the buffer holds data.
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && (occ == 2'd0)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a framed valid/ready stream at one beat per clock.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned PKT_LEN    = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  pkt_done,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);

    localparam int unsigned          IDX_WIDTH = 16;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(PKT_LEN - 1);

    logic                  inflight;
    occ_t                  occ;
    logic [DATA_WIDTH-1:0] head;
    logic [IDX_WIDTH-1:0]  beat_idx;
    logic [2:0]            credit_used;
    logic                  handshake;
    logic                  last_beat;

    // Words already committed: buffered entries plus the read still in the FIFO pipeline.
    assign credit_used = 3'(occ) + 3'(inflight);
    assign fifo_rd_en  = rst_n & enable & ~fifo_empty & (credit_used < 3'(BUF_DEPTH));

    assign m_valid   = (occ != 2'd0);
    assign m_data    = head;
    assign last_beat = (beat_idx == LAST_IDX);
    assign m_last    = m_valid & last_beat;
    assign handshake = m_valid & m_ready;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (handshake),
        .occ       (occ),
        .head      (head)
    );

    // FIFO read data is valid one cycle after the request; remember which cycles carry it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    // Beat position within the packet, completion pulse and packet counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx <= '0;
            pkt_done <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            pkt_done <= handshake & last_beat;
            if (handshake) begin
                beat_idx <= last_beat ? '0 : beat_idx + IDX_WIDTH'(1);
                if (last_beat) begin
                    pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench: behavioural FIFO + stream model, directed scenarios, then random traffic.
module tb_fifo_rd_stream;

    localparam int unsigned DW = 8;
    localparam int unsigned PL = 4;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          pkt_done;
    logic [CW-1:0] pkt_cnt;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (PL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .pkt_done   (pkt_done),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 clk = ~clk;

    // Words read from the FIFO but not yet delivered, with the cycle they may first appear.
    typedef struct {
        logic [DW-1:0] d;
        int            rdy;
    } ent_t;

    ent_t          pend[$];
    logic [DW-1:0] fq[$];
    int            cyc;
    int            beats;
    int            pkts;
    int            first_rd;
    int            rd_total;
    bit            done_exp;
    bit            rd_seen;
    int            checks   = 0;
    int            failures = 0;

    logic [DW-1:0] lg_d[$];
    bit            lg_l[$];
    int            lg_c[$];

    logic [DW-1:0] exp3 [4];
    int            r0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model and compare at the falling edge, when all DUT outputs for the cycle are settled.
    always @(negedge clk) begin
        bit ev;
        bit er;
        bit el;
        if (!rst_n) begin
            chk("rst_rd_en",    32'(fifo_rd_en), 32'(0));
            chk("rst_m_valid",  32'(m_valid),    32'(0));
            chk("rst_m_last",   32'(m_last),     32'(0));
            chk("rst_pkt_done", 32'(pkt_done),   32'(0));
            chk("rst_pkt_cnt",  32'(pkt_cnt),    32'(0));
            chk("rst_m_data",   32'(m_data),     32'(0));
            pend.delete();
            cyc      = 0;
            beats    = 0;
            pkts     = 0;
            done_exp = 1'b0;
            rd_seen  = 1'b0;
            first_rd = -1;
        end else begin
            ev = (pend.size() > 0) && (pend[0].rdy <= cyc);
            er = enable && (fq.size() > 0) && (pend.size() < 3);
            el = ev && ((beats % PL) == (PL - 1));
            chk("m_valid",    32'(m_valid),    32'(ev));
            chk("fifo_rd_en", 32'(fifo_rd_en), 32'(er));
            chk("m_last",     32'(m_last),     32'(el));
            chk("pkt_done",   32'(pkt_done),   32'(done_exp));
            chk("pkt_cnt",    32'(pkt_cnt),    32'(CW'(pkts)));
            if (ev) begin
                chk("m_data", 32'(m_data), 32'(pend[0].d));
            end
            done_exp = 1'b0;
            if (m_valid && m_ready) begin
                lg_d.push_back(m_data);
                lg_l.push_back(m_last);
                lg_c.push_back(cyc);
            end
            if (ev && m_ready) begin
                void'(pend.pop_front());
                if (el) begin
                    pkts++;
                    done_exp = 1'b1;
                end
                beats++;
            end
            if (fifo_rd_en) begin
                rd_total++;
                if (first_rd < 0) first_rd = cyc;
                if (fq.size() > 0) pend.push_back('{fq[0], cyc + 2});
            end
            rd_seen = fifo_rd_en;
            cyc++;
        end
    end

    // Advance n cycles; the FIFO model answers each read with data in the following cycle.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rd_seen && (fq.size() > 0)) fifo_data = fq.pop_front();
            fifo_empty = (fq.size() == 0);
        end
    endtask

    task automatic fwrite(input logic [DW-1:0] d);
        fq.push_back(d);
        fifo_empty = 1'b0;
    endtask

    task automatic clr_log();
        lg_d.delete();
        lg_l.delete();
        lg_c.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        m_ready    = 1'b1;
        fifo_data  = '0;
        fifo_empty = 1'b1;
        rd_total   = 0;

        // Reset held with words waiting, then an 8-word run of two packets.
        for (int i = 0; i < 8; i++) fwrite(8'(8'h10 + i));
        step(3);
        clr_log();
        rst_n = 1'b1;
        step(12);
        chk("t1_first_rd", 32'(first_rd), 32'(0));
        chk("t1_count", 32'(lg_d.size()), 32'(8));
        for (int i = 0; i < 8 && i < lg_d.size(); i++) begin
            chk("t1_data", 32'(lg_d[i]), 32'(8'h10 + i));
            chk("t1_last", 32'(lg_l[i]), 32'((i % 4) == 3));
            chk("t1_cyc",  32'(lg_c[i]), 32'(2 + i));
        end
        chk("t1_pkt_cnt", 32'(pkt_cnt), 32'(2));

        // Backpressure: reads stop at three outstanding, head word held.
        clr_log();
        m_ready = 1'b0;
        r0 = rd_total;
        for (int i = 0; i < 8; i++) fwrite(8'(8'h20 + i));
        step(5);
        chk("t2_reads", 32'(rd_total - r0), 32'(3));
        chk("t2_hold_data", 32'(m_data), 32'(8'h20));
        chk("t2_hold_valid", 32'(m_valid), 32'(1));
        m_ready = 1'b1;
        step(14);
        chk("t2_count", 32'(lg_d.size()), 32'(8));
        for (int i = 0; i < 8 && i < lg_d.size(); i++) begin
            chk("t2_data", 32'(lg_d[i]), 32'(8'h20 + i));
            chk("t2_last", 32'(lg_l[i]), 32'((i % 4) == 3));
        end
        chk("t2_pkt_cnt", 32'(pkt_cnt), 32'(4));

        // FIFO runs dry mid-packet; framing resumes when more words arrive.
        clr_log();
        exp3[0] = 8'h30; exp3[1] = 8'h31; exp3[2] = 8'hA0; exp3[3] = 8'hA1;
        fwrite(8'h30);
        fwrite(8'h31);
        step(6);
        chk("t3_gap_valid", 32'(m_valid), 32'(0));
        chk("t3_gap_cnt", 32'(pkt_cnt), 32'(4));
        fwrite(8'hA0);
        fwrite(8'hA1);
        step(6);
        chk("t3_count", 32'(lg_d.size()), 32'(4));
        for (int i = 0; i < 4 && i < lg_d.size(); i++) begin
            chk("t3_data", 32'(lg_d[i]), 32'(exp3[i]));
            chk("t3_last", 32'(lg_l[i]), 32'(i == 3));
        end
        chk("t3_pkt_cnt", 32'(pkt_cnt), 32'(5));

        // enable dropped with two reads issued: both delivered, no further reads.
        clr_log();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fwrite(8'(8'h40 + i));
        step(2);
        enable = 1'b0;
        r0 = rd_total;
        step(4);
        m_ready = 1'b1;
        step(8);
        chk("t4_reads_off", 32'(rd_total - r0), 32'(0));
        chk("t4_count", 32'(lg_d.size()), 32'(2));
        for (int i = 0; i < 2 && i < lg_d.size(); i++) begin
            chk("t4_data", 32'(lg_d[i]), 32'(8'h40 + i));
            chk("t4_last", 32'(lg_l[i]), 32'(0));
        end
        chk("t4_not_empty", 32'(fifo_empty), 32'(0));
        chk("t4_rd_en_off", 32'(fifo_rd_en), 32'(0));

        // Finish the open packet, start a new one, reset after its second beat.
        fq.delete();
        fifo_empty = 1'b1;
        clr_log();
        enable = 1'b1;
        fwrite(8'h50);
        fwrite(8'h51);
        step(6);
        chk("t5_close_count", 32'(lg_d.size()), 32'(2));
        if (lg_l.size() == 2) chk("t5_close_last", 32'(lg_l[1]), 32'(1));
        chk("t5_close_cnt", 32'(pkt_cnt), 32'(6));
        clr_log();
        for (int i = 0; i < 8; i++) fwrite(8'(8'h52 + i));
        step(4);
        chk("t5_pre_rst_count", 32'(lg_d.size()), 32'(2));
        rst_n = 1'b0;
        step(2);
        chk("t5_rst_cnt", 32'(pkt_cnt), 32'(0));
        chk("t5_rst_valid", 32'(m_valid), 32'(0));
        clr_log();
        rst_n = 1'b1;
        step(8);
        chk("t5_count", 32'(lg_d.size()), 32'(4));
        for (int i = 0; i < 4 && i < lg_d.size(); i++) begin
            chk("t5_data", 32'(lg_d[i]), 32'(8'h56 + i));
            chk("t5_last", 32'(lg_l[i]), 32'(i == 3));
        end
        chk("t5_pkt_cnt", 32'(pkt_cnt), 32'(1));

        // Random traffic with sporadic resets, checked every cycle by the model.
        for (int i = 0; i < 800; i++) begin
            enable  = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) fwrite(8'($urandom));
            rst_n = ($urandom_range(0, 199) != 0);
            step(1);
        end
        rst_n = 1'b1;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-domain consumer placed directly downstream of the async FIFO.
- Drains the FIFO's rd_en/empty/data_out interface and presents the words as a valid/ready stream with packet framing (last flag every PKT_LEN beats).
- Hides the FIFO memory's one-cycle registered read latency with a 3-entry output buffer, so it sustains one beat per clock.
- Runs entirely on the FIFO's read clock.

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO.
- PKT_LEN, 16, beats per packet; legal range 1..65535.
- CNT_WIDTH, 16, width of the packet counter.

Ports:
- clk  input  1  read-domain clock (same clock as the FIFO read side).
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  permits new FIFO reads; buffered data still drains when low.
- fifo_empty  input  1  FIFO empty flag, registered in clk domain.
- fifo_rd_en  output  1  FIFO read request.
- fifo_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- m_valid  output  1  stream data valid.
- m_ready  input  1  stream sink ready.
- m_data  output  DATA_WIDTH  stream data.
- m_last  output  1  final beat of the current packet.
- pkt_done  output  1  one-cycle pulse after a packet completes.
- pkt_cnt  output  CNT_WIDTH  number of completed packets; wraps.

Behaviour:
- Reset, asynchronous: buffer empty, inflight=0, beat_idx=0, pkt_cnt=0. Outputs m_valid=0, m_last=0, pkt_done=0, fifo_rd_en=0. m_data resets to 0.
- Read issue, combinational: fifo_rd_en = enable & ~fifo_empty & (occ + inflight < 3).
  - Never asserted while fifo_empty=1.
  - Never asserted while rst_n=0.
- inflight register: set to fifo_rd_en each cycle. On a cycle with inflight=1, fifo_data is written into the buffer tail at the clock edge.
- Buffer: 3-entry circular, 2-bit rd/wr indices, occ 0..3.
  - A push and a pop in the same cycle leave occ unchanged.
  - The credit rule guarantees no overflow. An overflow is an assertion failure.
- Latency: rd_en at cycle n -> capture at end of n+1 -> m_valid=1 in n+2 (with an empty buffer).
- Throughput: 1 beat/clk sustained with m_ready held high and the FIFO non-empty.
- Stream: m_valid = (occ != 0); m_data = head entry.
  - Handshake = m_valid & m_ready.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
- Framing:
  - beat_idx counts handshakes 0..PKT_LEN-1 and wraps to 0 after the last beat.
  - m_last = m_valid & (beat_idx == PKT_LEN-1).
  - PKT_LEN=1 gives m_last on every beat.
- Packet completion: on a handshake with m_last=1, pkt_done=1 in the next cycle only, and pkt_cnt increments at the same edge, wrapping at 2^CNT_WIDTH.
- enable deasserted mid-packet: no new reads. Buffered and inflight words still deliver. beat_idx is retained, so framing continues on re-enable.
- FIFO empties mid-packet: m_valid drops; beat_idx is held. No partial-packet flush.
- Reset mid-operation: all buffered and inflight data is discarded, and the packet position and counters return to 0.

Decomposition:
- Shared package fifo_pkg: DATA_WIDTH default constant, BUF_DEPTH=3 constant, an occupancy typedef of 2 bits.
- Sub-module fifo_skid_buf: the 3-entry buffer with push/pop, occ, head data, and an overflow assertion.
- fifo_rd_stream keeps the credit logic, inflight, framing counters and pkt_done.

Test Plan:
- Reset with FIFO holding 4 words -> while rst_n=0, fifo_rd_en=0, m_valid=0, pkt_cnt=0. First rd_en comes on the cycle after rst_n rises.
- PKT_LEN=4, FIFO preloaded 0x10..0x17, m_ready=1:
  - rd_en at cycles 0..7; m_valid from cycle 2; data 0x10..0x17 on consecutive cycles.
  - m_last on 0x13 and 0x17; pkt_done pulses after each; pkt_cnt ends at 2.
- Backpressure: m_ready=0 for 5 cycles with the FIFO non-empty:
  - at most 3 reads are issued, then fifo_rd_en=0;
  - m_data stays 0x10;
  - after m_ready=1, no word is lost or duplicated.
- FIFO empties after 2 words of a 4-beat packet:
  - m_valid=0, beat_idx holds at 2;
  - writes 0xA0 and 0xA1 arrive;
  - 0xA1 carries m_last; pkt_cnt increments once.
- enable=0 with 2 words inflight/buffered -> both delivered; then fifo_rd_en stays 0 despite fifo_empty=0.
- Reset mid-packet after beat 1 of 4 -> buffer clears. The next FIFO word is treated as beat 0, and m_last falls on the 4th beat after reset.
